// File: rtl/ones_gen_pkg.sv
// rtl/ones_gen_pkg.sv - shared state type and word-boundary helpers for ones_pattern_gen
package ones_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lowest word of weight n in a w-bit field: n ones packed at the LSB end.
    // Returned at the maximum supported width (16); callers size-cast to W.
    function automatic logic [15:0] first_word(input int n, input int w);
        logic [16:0] ones;
        logic [16:0] mask;
        ones = (17'd1 << n) - 17'd1;
        mask = (17'd1 << w) - 17'd1;
        return 16'(ones & mask);
    endfunction

    // Highest word of weight n in a w-bit field: n ones packed at the MSB end.
    function automatic logic [15:0] last_word(input int n, input int w);
        logic [16:0] ones;
        logic [16:0] mask;
        ones = ((17'd1 << n) - 17'd1) << (w - n);
        mask = (17'd1 << w) - 17'd1;
        return 16'(ones & mask);
    endfunction

endpackage

// File: rtl/ones_next_comb.sv
// rtl/ones_next_comb.sv - combinational Gosper step: next larger word with the same popcount
module ones_next_comb #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] next
);

    localparam int TZW = $clog2(W + 2);

    logic [W:0]     w_x;
    logic [W:0]     w_c;
    logic [W:0]     w_r;
    logic [W:0]     w_spread;
    logic [TZW-1:0] w_tz;

    // One extra bit of headroom so the carry out of x + c is not lost.
    assign w_x = {1'b0, x};
    assign w_c = w_x & (-w_x);
    assign w_r = w_x + w_c;

    // Trailing-zero count of the isolated lowest set bit; scan from the top
    // so the lowest set position wins.
    always_comb begin
        w_tz = '0;
        for (int i = W; i >= 0; i--) begin
            if (w_c[i]) begin
                w_tz = TZW'(i);
            end
        end
    end

    // Bits that rippled out of the lowest run are re-packed at the LSB end.
    assign w_spread = ((w_r ^ w_x) >> 2) >> w_tz;
    assign next     = W'(w_spread | w_r);

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - streams all W-bit words of a requested popcount in ascending order (option: ONES_GEN_INDEX_EN)
module ones_pattern_gen
    import ones_gen_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_ones,
    output logic          busy,
    output logic          err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
`ifdef ONES_GEN_INDEX_EN
    output logic [W-1:0]  out_idx,
`endif
    output logic          out_last
);

    localparam logic [CW-1:0] W_CW = CW'(W);

    state_t        r_state;
    logic [CW-1:0] r_n;
    logic [W-1:0]  r_word;
    logic          r_valid;
    logic          r_last;
    logic          r_busy;
    logic          r_err;

    logic [W-1:0]  w_next;
    logic [W-1:0]  w_req_first;
    logic [W-1:0]  w_req_last;
    logic [W-1:0]  w_cur_last;
    logic          w_accept;

    ones_next_comb #(.W(W)) u_next (
        .x    (r_word),
        .next (w_next)
    );

    assign w_req_first = W'(first_word(int'(num_ones), W));
    assign w_req_last  = W'(last_word(int'(num_ones), W));
    assign w_cur_last  = W'(last_word(int'(r_n), W));
    assign w_accept    = r_valid & out_ready;

    // Sequencer: latch the request, step the word on each handshake, and
    // precompute out_last from the word being loaded so it travels with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_ones > W_CW) begin
                            r_err <= 1'b1;
                        end else begin
                            r_n     <= num_ones;
                            r_word  <= w_req_first;
                            r_last  <= (w_req_first == w_req_last);
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_word  <= '0;
                            r_last  <= 1'b0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_word <= w_next;
                            r_last <= (w_next == w_cur_last);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ONES_GEN_INDEX_EN
    logic [W-1:0] r_idx;

    // Position of the presented word within the sequence; cleared when the
    // sequence ends so the next one starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == RUN && w_accept) begin
            r_idx <= r_last ? '0 : r_idx + 1'b1;
        end
    end

    assign out_idx = r_idx;
`endif

    assign busy      = r_busy;
    assign err       = r_err;
    assign out_valid = r_valid;
    assign out_word  = r_word;
    assign out_last  = r_last;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - self-checking bench for ones_pattern_gen
module tb_ones_pattern_gen;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_ones;
    logic          busy;
    logic          err;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_last;
`ifdef ONES_GEN_INDEX_EN
    logic [W-1:0]  out_idx;
`endif

    int checks = 0;
    int errors = 0;

    ones_pattern_gen #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ones  (num_ones),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
`ifdef ONES_GEN_INDEX_EN
        .out_idx   (out_idx),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: every W-bit value with popcount n, in ascending order.
    task automatic build_model(input int n, output logic [W-1:0] q[$]);
        q = {};
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v) == n) q.push_back(W'(v));
        end
    endtask

    // Start a sequence of weight n and consume it; rnd selects random ready,
    // inject_at (>=0) raises a start with N=1 while that word is presented.
    task automatic run_seq(input int n, input bit rnd, input int inject_at, input int exp_total);
        logic [W-1:0] q[$];
        int got;
        int guard;
        int cycles;
        build_model(n, q);
        chk($sformatf("n%0d_model_size", n), q.size(), exp_total);
        start    = 1'b1;
        num_ones = CW'(n);
        step();
        start = 1'b0;
        chk($sformatf("n%0d_busy_first", n), busy, 1);
        got    = 0;
        guard  = 0;
        cycles = 0;
        while (got < q.size() && guard < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got == inject_at) begin
                start    = 1'b1;
                num_ones = CW'(1);
            end
            chk($sformatf("n%0d_valid_%0d", n, got), out_valid, 1);
            chk($sformatf("n%0d_word_%0d", n, got), out_word, q[got]);
            chk($sformatf("n%0d_last_%0d", n, got), out_last, (got == q.size() - 1));
`ifdef ONES_GEN_INDEX_EN
            chk($sformatf("n%0d_idx_%0d", n, got), out_idx, got);
`endif
            if (out_ready) got++;
            cycles++;
            step();
            start = 1'b0;
            guard++;
        end
        chk($sformatf("n%0d_no_timeout", n), (guard < 2000), 1);
        chk($sformatf("n%0d_total", n), got, exp_total);
        if (!rnd) chk($sformatf("n%0d_cycles", n), cycles, exp_total);
        chk($sformatf("n%0d_end_busy", n), busy, 0);
        chk($sformatf("n%0d_end_valid", n), out_valid, 0);
        chk($sformatf("n%0d_end_word", n), out_word, 0);
        chk($sformatf("n%0d_end_err", n), err, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_ones  = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_word, 0);
        chk("rst_last", out_last, 0);
        rst = 1'b0;
        step();

        run_seq(2, 1'b0, -1, 28);
        run_seq(0, 1'b0, -1, 1);
        run_seq(8, 1'b0, -1, 1);

        start    = 1'b1;
        num_ones = CW'(9);
        step();
        start = 1'b0;
        chk("n9_err_pulse", err, 1);
        chk("n9_valid", out_valid, 0);
        chk("n9_busy", busy, 0);
        step();
        chk("n9_err_cleared", err, 0);
        chk("n9_valid_after", out_valid, 0);

        run_seq(3, 1'b1, -1, 56);
        run_seq(4, 1'b0, 9, 70);

        start    = 1'b1;
        num_ones = CW'(5);
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("n5_mid_valid", out_valid, 1);
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_word", out_word, 0);
        chk("mid_rst_last", out_last, 0);
        step();
        chk("post_rst_idle_valid", out_valid, 0);
        run_seq(1, 1'b0, -1, 8);

        for (int k = 0; k < 3; k++) begin
            int n;
            int total;
            n = int'($urandom_range(0, W));
            total = 1;
            for (int j = 0; j < n; j++) total = total * (W - j) / (j + 1);
            run_seq(n, 1'b1, -1, total);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
